ucsbece154b_icache_cwf: RTL and testbench
=========================================

# ucsbece154b_icache_cwf

Parametrised set-associative instruction cache, next generation of the fetch-stage icache. It sits between the core fetch stage (PCNewF) and the SDRAM controller. Over the current cache it adds critical-word-first burst refill with early restart, selectable true-LRU or round-robin replacement, and a single-cycle Flush (fence.i). All geometry is parametrised.

## Interface
- NUM_SETS, 8, number of sets; power of 2, ≥2
- NUM_WAYS, 4, associativity; power of 2, ≥2
- BLOCK_WORDS, 4, words per line; power of 2, ≥2
- WORD_SIZE, 32, instruction width in bits
- REPL_MODE, 0, replacement policy: 0 = true LRU (per-way age counters), 1 = per-set round-robin pointer
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- ReadEnable  in  1  fetch request; address sampled on the rising edge
- ReadAddress  in  32  byte address (PCNewF); bits [1:0] ignored
- Flush  in  1  invalidate all lines
- Instruction  out  WORD_SIZE  fetched word; registered
- Ready  out  1  one-cycle pulse; Instruction is valid for the sampled address
- Busy  out  1  refill in progress; ReadEnable is ignored while high
- MemReadAddress  out  32  word-aligned address of the critical word
- MemReadRequest  out  1  held high for the whole burst
- MemDataIn  in  32  burst data
- MemDataReady  in  1  MemDataIn is valid this cycle

## Operation
- Address split: offset = addr[OB+1:2], OB = log2(BLOCK_WORDS); index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Storage: per set/way, a valid bit, a tag, BLOCK_WORDS data words, and replacement state (LRU ages of log2(NUM_WAYS) bits, or one RR pointer per set).
- FSM states:
  - IDLE: serves accesses; hit or miss is evaluated on the ReadEnable edge.
  - REFILL: burst in progress.
  - FINISH: one-cycle line validate and return to IDLE.
- Hit (IDLE, ReadEnable): Instruction <= matching word; Ready <= 1; replacement state updated (hit way age 0; younger ways +1). Round-robin mode leaves the pointer unchanged on hit.
- Miss (IDLE, ReadEnable, no tag match):
  - Latch index, tag and offset.
  - Choose victim: the lowest-index invalid way if any; else the oldest way (age NUM_WAYS-1) in LRU mode, or the RR pointer in round-robin mode.
  - Clear the victim's valid bit.
  - MemReadAddress <= {addr[31:2],2'b00}; MemReadRequest <= 1; Busy <= 1; go to REFILL.
- Burst order contract: the controller returns BLOCK_WORDS words starting at MemReadAddress and wrapping modulo the line. The word counter is OB bits wide. The write offset is (latched offset + counter) mod BLOCK_WORDS.
- REFILL: each MemDataReady writes one word.
  - First beat (critical word): Instruction <= MemDataIn; Ready <= 1 (early restart).
  - Last beat: MemReadRequest <= 0; go to FINISH.
- FINISH:
  - Write the tag and set valid, unless the refill was discarded.
  - Update replacement state: victim becomes MRU, or RR pointer increments mod NUM_WAYS.
  - Busy <= 0; go to IDLE.
- Flush:
  - In IDLE: all valid bits cleared on the edge. Flush has priority over a same-cycle ReadEnable, which is dropped (no Ready).
  - In REFILL/FINISH: valid bits cleared and a discard flag set. The burst still drains to completion (all beats consumed) and the critical-word Ready still fires. FINISH does not set valid.
- ReadEnable during Busy: no effect, no Ready. The core re-presents the PC after Busy falls.

## Timing
- Reset values: Instruction 0, Ready 0, Busy 0, MemReadRequest 0, MemReadAddress 0. All valid bits, ages and RR pointers are 0; FSM in IDLE; discard flag clear.
- Reset mid-burst: outputs return to reset values on the next edge. Remaining MemDataReady beats are ignored.
- Hit latency: ReadEnable sampled at edge N; Ready=1 and Instruction valid during cycle N+1. Back-to-back hits give one Ready per cycle.
- Miss: Busy and MemReadRequest rise at edge N. The critical word arriving with MemDataReady at edge M gives Ready during cycle M+1.
- After the last beat at edge L: MemReadRequest falls at L. Busy falls at L+1 (FINISH). The first new access is sampled at L+2.
- The cache tolerates any number of idle cycles between beats. MemReadAddress is stable while MemReadRequest is high.
- Ready is never high for two cycles from one request.

## Test plan
- Cold miss, 0x0000_0048, default params: MemReadAddress=0x48, MemReadRequest=1.
  - Beats D0..D3 write offsets 2,3,0,1.
  - Ready with D0 the cycle after beat 1; Busy low 2 cycles after beat 4.
  - Re-read 0x40 → hit with D2 next cycle.
- Hit streaming: four sequential PCs in one cached line → four consecutive Ready pulses, no MemReadRequest.
- LRU: fill ways 0–3 of set 0 (tags 1–4), re-hit tag 1, miss tag 5 → way 1 (tag 2) is replaced. With REPL_MODE=1 the same sequence replaces way 0.
- Flush during REFILL after beat 2: the burst completes, critical-word Ready fires, the line stays invalid, and a re-read misses.
- Reset asserted mid-burst, then deasserted: all outputs 0 next cycle; a previously valid address misses.
- Parameter sweep (NUM_SETS=16, NUM_WAYS=2, BLOCK_WORDS=8): critical-word wrap at offset 7 writes offsets 7,0..6. Hit and miss results match a reference model over 10k random addresses.

Source files
------------

// File: rtl/ucsbece154b_icache_cwf.sv
// Set-associative instruction cache with critical-word-first refill and early restart.
// Replacement is true LRU (per-way ages) or per-set round-robin, chosen by REPL_MODE.
module ucsbece154b_icache_cwf #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32,
    parameter int REPL_MODE   = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 ReadEnable,
    input  logic [31:0]          ReadAddress,
    input  logic                 Flush,
    output logic [WORD_SIZE-1:0] Instruction,
    output logic                 Ready,
    output logic                 Busy,
    output logic [31:0]          MemReadAddress,
    output logic                 MemReadRequest,
    input  logic [31:0]          MemDataIn,
    input  logic                 MemDataReady
);
    localparam int OB = $clog2(BLOCK_WORDS);
    localparam int IB = $clog2(NUM_SETS);
    localparam int WB = $clog2(NUM_WAYS);
    localparam int TW = 30 - OB - IB;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]                       state;
    logic [NUM_WAYS-1:0]              valid [NUM_SETS];
    logic [TW-1:0]                    tags  [NUM_SETS][NUM_WAYS];
    logic [WORD_SIZE-1:0]             data  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [NUM_WAYS-1:0][WB-1:0]      age   [NUM_SETS];
    logic [WB-1:0]                    rr    [NUM_SETS];

    logic [IB-1:0] r_idx;
    logic [TW-1:0] r_tag;
    logic [OB-1:0] r_off, cnt, wr_off;
    logic [WB-1:0] r_way;
    logic          discard;

    logic [OB-1:0] a_off;
    logic [IB-1:0] a_idx;
    logic [TW-1:0] a_tag;
    logic          unused_bits;

    assign a_off       = ReadAddress[OB+1:2];
    assign a_idx       = ReadAddress[OB+IB+1:OB+2];
    assign a_tag       = ReadAddress[31:OB+IB+2];
    assign unused_bits = ^ReadAddress[1:0];
    assign wr_off      = r_off + cnt;

    logic          hit;
    logic [WB-1:0] hit_way, lru_way, victim;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        lru_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[a_idx][w] && tags[a_idx][w] == a_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (age[a_idx][w] == WB'(NUM_WAYS-1))
                lru_way = WB'(w);
        end
        victim = (REPL_MODE != 0) ? rr[a_idx] : lru_way;
        // Walk downward so the lowest-index invalid way wins.
        for (int w = NUM_WAYS-1; w >= 0; w--)
            if (!valid[a_idx][w]) victim = WB'(w);
    end

    // Touched way becomes age 0; ways not older than it age by one. The saturating
    // guard lets the all-zero reset state settle into a proper age permutation.
    logic                        upd_en;
    logic [IB-1:0]               upd_set;
    logic [WB-1:0]               upd_way;
    logic [NUM_WAYS-1:0][WB-1:0] new_age;

    always_comb begin
        upd_en  = (state == S_FINISH) || (state == S_IDLE && ReadEnable && !Flush && hit);
        upd_set = (state == S_FINISH) ? r_idx : a_idx;
        upd_way = (state == S_FINISH) ? r_way : hit_way;
        new_age = age[upd_set];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (WB'(w) == upd_way)
                new_age[w] = '0;
            else if (age[upd_set][w] <= age[upd_set][upd_way] &&
                     age[upd_set][w] != WB'(NUM_WAYS-1))
                new_age[w] = age[upd_set][w] + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && state == S_REFILL && MemDataReady)
            data[r_idx][r_way][wr_off] <= WORD_SIZE'(MemDataIn);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= S_IDLE;
            Instruction    <= '0;
            Ready          <= 1'b0;
            Busy           <= 1'b0;
            MemReadRequest <= 1'b0;
            MemReadAddress <= '0;
            cnt            <= '0;
            discard        <= 1'b0;
            r_idx          <= '0;
            r_tag          <= '0;
            r_off          <= '0;
            r_way          <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                age[s]   <= '0;
                rr[s]    <= '0;
            end
        end else begin
            Ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ReadEnable && !Flush) begin
                        if (hit) begin
                            Instruction <= data[a_idx][hit_way][a_off];
                            Ready       <= 1'b1;
                        end else begin
                            r_idx                 <= a_idx;
                            r_tag                 <= a_tag;
                            r_off                 <= a_off;
                            r_way                 <= victim;
                            valid[a_idx][victim]  <= 1'b0;
                            MemReadAddress        <= {ReadAddress[31:2], 2'b00};
                            MemReadRequest        <= 1'b1;
                            Busy                  <= 1'b1;
                            cnt                   <= '0;
                            discard               <= 1'b0;
                            state                 <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (MemDataReady) begin
                        if (cnt == '0) begin
                            Instruction <= WORD_SIZE'(MemDataIn);
                            Ready       <= 1'b1;
                        end
                        if (cnt == OB'(BLOCK_WORDS-1)) begin
                            MemReadRequest <= 1'b0;
                            state          <= S_FINISH;
                        end
                        cnt <= cnt + 1'b1;
                    end
                    if (Flush) discard <= 1'b1;
                end
                S_FINISH: begin
                    if (!discard) valid[r_idx][r_way] <= 1'b1;
                    tags[r_idx][r_way] <= r_tag;
                    if (REPL_MODE != 0) rr[r_idx] <= rr[r_idx] + 1'b1;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (upd_en && REPL_MODE == 0) age[upd_set] <= new_age;
            // Placed last so a flush overrides any same-edge validate.
            if (Flush)
                for (int s = 0; s < NUM_SETS; s++) valid[s] <= '0;
        end
    end
endmodule

// File: tb/tb_ucsbece154b_icache_cwf.sv
// Scoreboard bench: instance 0 is the default LRU cache, instance 1 is a
// 16-set / 2-way / 8-word round-robin cache. Memory word = 0xD0000000 | address.
module tb_ucsbece154b_icache_cwf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, re, fl, mdr, rdy, busy, mrr;
    logic [1:0][31:0] ra, md, mra, ins;

    ucsbece154b_icache_cwf u_lru (
        .Clk(clk), .Reset(rst[0]), .ReadEnable(re[0]), .ReadAddress(ra[0]), .Flush(fl[0]),
        .Instruction(ins[0]), .Ready(rdy[0]), .Busy(busy[0]), .MemReadAddress(mra[0]),
        .MemReadRequest(mrr[0]), .MemDataIn(md[0]), .MemDataReady(mdr[0]));

    ucsbece154b_icache_cwf #(.NUM_SETS(16), .NUM_WAYS(2), .BLOCK_WORDS(8), .REPL_MODE(1)) u_rr (
        .Clk(clk), .Reset(rst[1]), .ReadEnable(re[1]), .ReadAddress(ra[1]), .Flush(fl[1]),
        .Instruction(ins[1]), .Ready(rdy[1]), .Busy(busy[1]), .MemReadAddress(mra[1]),
        .MemReadRequest(mrr[1]), .MemDataIn(md[1]), .MemDataReady(mdr[1]));

    int nvec = 0, nerr = 0;
    logic [31:0] q0[$], q1[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hD000_0000 | (a & 32'h00FF_FFFC);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [31:0] v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    // Monitor: every Ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rdy[0]) begin
            if (q0.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL ready0: unexpected Ready, instr %h", ins[0]);
            end else chk("instr0", ins[0], q0.pop_front());
        end
        if (rdy[1]) begin
            if (q1.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL ready1: unexpected Ready, instr %h", ins[1]);
            end else chk("instr1", ins[1], q1.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sampling edge.
    task automatic acc(input int i, input logic [31:0] a, input bit miss);
        re[i] = 1'b1; ra[i] = a;
        if (!miss) push(i, mem(a));
        @(posedge clk); #1;
        re[i] = 1'b0;
        chk("busy_after_access", 32'(busy[i]), 32'(miss));
        if (miss) begin
            chk("mem_read_address", mra[i], {a[31:2], 2'b00});
            chk("mem_read_request", 32'(mrr[i]), 32'd1);
            push(i, mem(a));
        end
    endtask

    // Controller model: wrapped burst from the critical word; optional idle gaps
    // between beats and a Flush pulse issued alongside beat index fk.
    task automatic burst(input int i, input logic [31:0] a, input int gap, input int fk);
        int bw, off;
        logic [31:0] base;
        bw   = (i == 0) ? 4 : 8;
        base = a & ~(32'(bw * 4) - 32'd1);
        off  = int'(a[6:2]) % bw;
        for (int k = 0; k < bw; k++) begin
            mdr[i] = 1'b1;
            md[i]  = mem(base + 32'(((off + k) % bw) * 4));
            fl[i]  = (k == fk);
            @(posedge clk); #1;
            mdr[i] = 1'b0; fl[i] = 1'b0;
            if (k < bw - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        chk("mrr_after_last_beat", 32'(mrr[i]), 32'd0);
        chk("busy_in_finish", 32'(busy[i]), 32'd1);
        @(posedge clk); #1;
        chk("busy_after_finish", 32'(busy[i]), 32'd0);
    endtask

    task automatic chk_reset(input int i);
        chk("rst_instr", ins[i], 32'd0);
        chk("rst_ready", 32'(rdy[i]), 32'd0);
        chk("rst_busy", 32'(busy[i]), 32'd0);
        chk("rst_mrr", 32'(mrr[i]), 32'd0);
        chk("rst_mra", mra[i], 32'd0);
    endtask

    initial begin
        rst = 2'b11; re = '0; fl = '0; mdr = '0; ra = '0; md = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst = 2'b00;

        // Cold miss at 0x48 with idle gaps, then streaming hits in the line.
        acc(0, 32'h48, 1); burst(0, 32'h48, 1, -1);
        acc(0, 32'h40, 0);
        acc(0, 32'h40, 0); acc(0, 32'h44, 0); acc(0, 32'h48, 0); acc(0, 32'h4C, 0);

        // LRU: set 0 tags 1..4, re-hit tag 1, tag 5 must evict tag 2.
        acc(0, 32'h080, 1); burst(0, 32'h080, 0, -1);
        acc(0, 32'h100, 1); burst(0, 32'h100, 0, -1);
        acc(0, 32'h180, 1); burst(0, 32'h180, 0, -1);
        acc(0, 32'h200, 1); burst(0, 32'h200, 0, -1);
        acc(0, 32'h084, 0);
        acc(0, 32'h28C, 1); burst(0, 32'h28C, 0, -1);
        acc(0, 32'h080, 0); acc(0, 32'h188, 0); acc(0, 32'h204, 0); acc(0, 32'h280, 0);
        acc(0, 32'h100, 1); burst(0, 32'h100, 0, -1);

        // Flush during refill after beat 2: burst drains, line stays invalid.
        acc(0, 32'h510, 1); burst(0, 32'h510, 0, 2);
        acc(0, 32'h510, 1); burst(0, 32'h510, 2, -1);
        acc(0, 32'h514, 0);
        acc(0, 32'h40, 1);  burst(0, 32'h40, 0, -1);

        // Flush in IDLE beats a same-cycle ReadEnable.
        re[0] = 1'b1; ra[0] = 32'h514; fl[0] = 1'b1;
        @(posedge clk); #1;
        re[0] = 1'b0; fl[0] = 1'b0;
        chk("flush_idle_busy", 32'(busy[0]), 32'd0);
        acc(0, 32'h518, 1); burst(0, 32'h518, 0, -1);

        // Reset mid-burst, trailing beats ignored, prior line gone.
        acc(0, 32'h620, 1);
        mdr[0] = 1'b1; md[0] = mem(32'h620);
        @(posedge clk); #1;
        mdr[0] = 1'b0; rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk_reset(0);
        for (int k = 1; k < 4; k++) begin
            mdr[0] = 1'b1; md[0] = mem(32'h620 + 32'(k * 4));
            @(posedge clk); #1;
            mdr[0] = 1'b0;
        end
        chk("post_reset_busy", 32'(busy[0]), 32'd0);
        acc(0, 32'h514, 1); burst(0, 32'h514, 0, -1);
        acc(0, 32'h510, 0);

        // 8-word line: critical word at offset 7 wraps to 0..6.
        acc(1, 32'h1C, 1); burst(1, 32'h1C, 0, -1);
        for (int k = 0; k < 8; k++) acc(1, 32'(k * 4), 0);

        // Round-robin: pointer picks way 0 even though way 0 was just hit.
        acc(1, 32'h200, 1); burst(1, 32'h200, 1, -1);
        acc(1, 32'h000, 0);
        acc(1, 32'h400, 1); burst(1, 32'h400, 0, -1);
        acc(1, 32'h208, 0);
        acc(1, 32'h404, 0);
        acc(1, 32'h004, 1); burst(1, 32'h004, 0, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
